// File: rtl/pfft_mul_pipe.sv
// Pipelined fixed-point multiplier: signed/unsigned product, right-shift with round-half-even,
// saturation with overflow flag, tag sideband and a valid/ready handshake with one global stall.
module pfft_mul_pipe #(
    parameter int unsigned A_W       = 59,
    parameter int unsigned B_W       = 61,
    parameter int unsigned OUT_W     = 119,
    parameter int unsigned SHIFT     = 0,
    parameter int unsigned NUM_STAGE = 3,
    parameter int unsigned TAG_W     = 8
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic             s_signed,
    input  logic [A_W-1:0]   s_a,
    input  logic [B_W-1:0]   s_b,
    input  logic [TAG_W-1:0] s_tag,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [OUT_W-1:0] m_data,
    output logic             m_ovf,
    output logic [TAG_W-1:0] m_tag
);

    localparam int unsigned PW  = A_W + B_W;
    localparam int unsigned VW  = (PW + 2 > OUT_W + 2) ? PW + 2 : OUT_W + 2;
    localparam int unsigned SH1 = (SHIFT > 0) ? SHIFT - 1 : 0;

    localparam logic [PW:0] HALF_MASK = (SHIFT > 0) ? ((PW + 1)'(1) << SH1) : '0;
    localparam logic [PW:0] LOW_MASK  = (SHIFT > 1) ? (HALF_MASK - (PW + 1)'(1)) : '0;

    localparam logic signed [VW-1:0] ONE_V = VW'(1);
    localparam logic signed [VW-1:0] UMAX  = (ONE_V <<< OUT_W) - ONE_V;
    localparam logic signed [VW-1:0] SMAX  = (ONE_V <<< (OUT_W - 1)) - ONE_V;
    localparam logic signed [VW-1:0] SMIN  = -(ONE_V <<< (OUT_W - 1));

    // Product carried as PW+1 bits: wide enough for both the signed and unsigned ranges.
    function automatic logic [PW:0] mul_full(input logic [A_W-1:0] a, input logic [B_W-1:0] b,
                                             input logic sgn);
        logic [PW:0] ax;
        logic [PW:0] bx;
        ax = {{(B_W + 1){sgn & a[A_W-1]}}, a};
        bx = {{(A_W + 1){sgn & b[B_W-1]}}, b};
        return ax * bx;
    endfunction

    function automatic logic [OUT_W:0] round_sat(input logic [PW:0] p, input logic sgn);
        logic [PW:0]           q;
        logic                  rnd;
        logic signed [VW-1:0]  v;
        q   = $unsigned($signed(p) >>> SHIFT);
        rnd = (|(p & HALF_MASK)) & ((|(p & LOW_MASK)) | q[0]);
        v   = $signed({{(VW - PW - 1){q[PW]}}, q}) + $signed({{(VW - 1){1'b0}}, rnd});
        if (!sgn) begin
            if (v > UMAX) return {1'b1, {OUT_W{1'b1}}};
            return {1'b0, v[OUT_W-1:0]};
        end
        if (v > SMAX) return {1'b1, SMAX[OUT_W-1:0]};
        if (v < SMIN) return {1'b1, SMIN[OUT_W-1:0]};
        return {1'b0, v[OUT_W-1:0]};
    endfunction

    logic             adv;
    logic             out_valid_q;
    logic [OUT_W-1:0] out_data_q;
    logic             out_ovf_q;
    logic [TAG_W-1:0] out_tag_q;

    logic             fin_valid;
    logic             fin_sgn;
    logic [PW:0]      fin_p;
    logic [TAG_W-1:0] fin_tag;
    logic [OUT_W:0]   fin_res;

    assign adv     = !out_valid_q || m_ready;
    assign s_ready = adv;

    generate
        if (NUM_STAGE == 1) begin : g_single
            always_comb begin
                fin_valid = s_valid;
                fin_sgn   = s_signed;
                fin_p     = mul_full(s_a, s_b, s_signed);
                fin_tag   = s_tag;
            end
        end else begin : g_multi
            logic             in_valid_q;
            logic             in_sgn_q;
            logic [A_W-1:0]   in_a_q;
            logic [B_W-1:0]   in_b_q;
            logic [TAG_W-1:0] in_tag_q;

            always_ff @(posedge ap_clk) begin
                if (!ap_rst_n) begin
                    in_valid_q <= 1'b0;
                end else if (adv) begin
                    in_valid_q <= s_valid;
                end
            end

            always_ff @(posedge ap_clk) begin
                if (adv) begin
                    in_sgn_q <= s_signed;
                    in_a_q   <= s_a;
                    in_b_q   <= s_b;
                    in_tag_q <= s_tag;
                end
            end

            if (NUM_STAGE == 2) begin : g_nomid
                always_comb begin
                    fin_valid = in_valid_q;
                    fin_sgn   = in_sgn_q;
                    fin_p     = mul_full(in_a_q, in_b_q, in_sgn_q);
                    fin_tag   = in_tag_q;
                end
            end else begin : g_mid
                // Product delay line; retiming is free to spread the multiplier across it.
                logic             mid_valid_q [NUM_STAGE-2];
                logic             mid_sgn_q   [NUM_STAGE-2];
                logic [PW:0]      mid_p_q     [NUM_STAGE-2];
                logic [TAG_W-1:0] mid_tag_q   [NUM_STAGE-2];

                always_ff @(posedge ap_clk) begin
                    if (!ap_rst_n) begin
                        for (int i = 0; i < int'(NUM_STAGE) - 2; i++) begin
                            mid_valid_q[i] <= 1'b0;
                        end
                    end else if (adv) begin
                        mid_valid_q[0] <= in_valid_q;
                        for (int i = 1; i < int'(NUM_STAGE) - 2; i++) begin
                            mid_valid_q[i] <= mid_valid_q[i-1];
                        end
                    end
                end

                always_ff @(posedge ap_clk) begin
                    if (adv) begin
                        mid_sgn_q[0] <= in_sgn_q;
                        mid_p_q[0]   <= mul_full(in_a_q, in_b_q, in_sgn_q);
                        mid_tag_q[0] <= in_tag_q;
                        for (int i = 1; i < int'(NUM_STAGE) - 2; i++) begin
                            mid_sgn_q[i] <= mid_sgn_q[i-1];
                            mid_p_q[i]   <= mid_p_q[i-1];
                            mid_tag_q[i] <= mid_tag_q[i-1];
                        end
                    end
                end

                always_comb begin
                    fin_valid = mid_valid_q[NUM_STAGE-3];
                    fin_sgn   = mid_sgn_q[NUM_STAGE-3];
                    fin_p     = mid_p_q[NUM_STAGE-3];
                    fin_tag   = mid_tag_q[NUM_STAGE-3];
                end
            end
        end
    endgenerate

    assign fin_res = round_sat(fin_p, fin_sgn);

    // Output payload only loads with a valid result so it stays put across bubbles.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
            out_tag_q   <= '0;
        end else if (adv) begin
            out_valid_q <= fin_valid;
            if (fin_valid) begin
                out_ovf_q  <= fin_res[OUT_W];
                out_data_q <= fin_res[OUT_W-1:0];
                out_tag_q  <= fin_tag;
            end
        end
    end

    assign m_valid = out_valid_q;
    assign m_data  = out_data_q;
    assign m_ovf   = out_ovf_q;
    assign m_tag   = out_tag_q;

endmodule

// File: tb/tb_pfft_mul_pipe.sv
// Directed and random checks for pfft_mul_pipe across several parameter sets sharing one
// stimulus bus: 8-bit configs (SHIFT=8, SHIFT=4) and default-width configs (depth 3, 1, 6).
module tb_pfft_mul_pipe;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n;
    logic        s_valid;
    logic        s_signed;
    logic        m_ready;
    logic [7:0]  s_a8, s_b8, s_tag;
    logic [58:0] s_aw;
    logic [60:0] s_bw;

    logic        t_ready, t_valid, t_ovf;
    logic [7:0]  t_data, t_tag;
    logic        s4_ready, s4_valid, s4_ovf;
    logic [7:0]  s4_data, s4_tag;
    logic         d_ready, d_valid, d_ovf;
    logic [118:0] d_data;
    logic [7:0]   d_tag;
    logic         n1_ready, n1_valid, n1_ovf;
    logic [118:0] n1_data;
    logic [7:0]   n1_tag;
    logic         n6_ready, n6_valid, n6_ovf;
    logic [118:0] n6_data;
    logic [7:0]   n6_tag;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [118:0] data;
        logic         ovf;
        logic [7:0]   tag;
    } exp_t;

    exp_t sb[$];

    // captured results from run_all
    logic [7:0]   rt_d, rt_tag, rs_d;
    logic         rt_o, rs_o, rd_o, r1_o, r6_o;
    logic [118:0] rd_d, r1_d, r6_d;
    logic [7:0]   rd_tag;
    int           lt, ls, ld, l1, l6;

    localparam logic [118:0] ONES119 = {119{1'b1}};
    localparam logic [118:0] SMAX119 = {1'b0, {118{1'b1}}};

    always #5 ap_clk = ~ap_clk;

    pfft_mul_pipe #(.A_W(8), .B_W(8), .OUT_W(8), .SHIFT(8), .NUM_STAGE(3), .TAG_W(8)) dut_t (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .s_valid(s_valid), .s_ready(t_ready),
        .s_signed(s_signed), .s_a(s_a8), .s_b(s_b8), .s_tag(s_tag), .m_valid(t_valid),
        .m_ready(m_ready), .m_data(t_data), .m_ovf(t_ovf), .m_tag(t_tag)
    );

    pfft_mul_pipe #(.A_W(8), .B_W(8), .OUT_W(8), .SHIFT(4), .NUM_STAGE(3), .TAG_W(8)) dut_s4 (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .s_valid(s_valid), .s_ready(s4_ready),
        .s_signed(s_signed), .s_a(s_a8), .s_b(s_b8), .s_tag(s_tag), .m_valid(s4_valid),
        .m_ready(m_ready), .m_data(s4_data), .m_ovf(s4_ovf), .m_tag(s4_tag)
    );

    pfft_mul_pipe dut_d (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .s_valid(s_valid), .s_ready(d_ready),
        .s_signed(s_signed), .s_a(s_aw), .s_b(s_bw), .s_tag(s_tag), .m_valid(d_valid),
        .m_ready(m_ready), .m_data(d_data), .m_ovf(d_ovf), .m_tag(d_tag)
    );

    pfft_mul_pipe #(.NUM_STAGE(1)) dut_n1 (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .s_valid(s_valid), .s_ready(n1_ready),
        .s_signed(s_signed), .s_a(s_aw), .s_b(s_bw), .s_tag(s_tag), .m_valid(n1_valid),
        .m_ready(m_ready), .m_data(n1_data), .m_ovf(n1_ovf), .m_tag(n1_tag)
    );

    pfft_mul_pipe #(.NUM_STAGE(6)) dut_n6 (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .s_valid(s_valid), .s_ready(n6_ready),
        .s_signed(s_signed), .s_a(s_aw), .s_b(s_bw), .s_tag(s_tag), .m_valid(n6_valid),
        .m_ready(m_ready), .m_data(n6_data), .m_ovf(n6_ovf), .m_tag(n6_tag)
    );

    // Golden model: exact product, floor shift, remainder-vs-half rounding, clamp.
    function automatic logic [128:0] model(input logic [127:0] a, input logic [127:0] b,
                                           input logic sgn, input int aw, input int bw,
                                           input int sh, input int ow);
        logic signed [263:0] one, ax, bx, p, q, r, hi, lo;
        one = 1;
        ax = a & ((one <<< aw) - 1);
        bx = b & ((one <<< bw) - 1);
        if (sgn && a[aw-1]) ax = ax - (one <<< aw);
        if (sgn && b[bw-1]) bx = bx - (one <<< bw);
        p = ax * bx;
        q = p >>> sh;
        r = p - (q <<< sh);
        if (sh > 0) begin
            if (((r <<< 1) > (one <<< sh)) || (((r <<< 1) == (one <<< sh)) && q[0])) q = q + 1;
        end
        hi = sgn ? (one <<< (ow - 1)) - 1 : (one <<< ow) - 1;
        lo = sgn ? -(one <<< (ow - 1)) : 0;
        if (q > hi) return {1'b1, hi[127:0] & ((128'd1 << ow) - 1)};
        if (q < lo) return {1'b1, lo[127:0] & ((128'd1 << ow) - 1)};
        return {1'b0, q[127:0] & ((128'd1 << ow) - 1)};
    endfunction

    task automatic flush();
        s_valid = 1'b0;
        m_ready = 1'b1;
        repeat (10) @(negedge ap_clk);
    endtask

    // One transfer into every instance; records first-valid latency and payload of each.
    task automatic run_all(input logic [7:0] a8, input logic [7:0] b8, input logic [58:0] aw,
                           input logic [60:0] bw, input logic sgn, input logic [7:0] tg);
        @(negedge ap_clk);
        s_a8 = a8; s_b8 = b8; s_aw = aw; s_bw = bw; s_signed = sgn; s_tag = tg;
        s_valid = 1'b1; m_ready = 1'b1;
        @(negedge ap_clk);
        s_valid = 1'b0;
        lt = -1; ls = -1; ld = -1; l1 = -1; l6 = -1;
        for (int n = 1; n <= 10; n++) begin
            #1;
            if (t_valid && lt < 0) begin lt = n; rt_d = t_data; rt_o = t_ovf; rt_tag = t_tag; end
            if (s4_valid && ls < 0) begin ls = n; rs_d = s4_data; rs_o = s4_ovf; end
            if (d_valid && ld < 0) begin ld = n; rd_d = d_data; rd_o = d_ovf; rd_tag = d_tag; end
            if (n1_valid && l1 < 0) begin l1 = n; r1_d = n1_data; r1_o = n1_ovf; end
            if (n6_valid && l6 < 0) begin l6 = n; r6_d = n6_data; r6_o = n6_ovf; end
            @(negedge ap_clk);
        end
    endtask

    task automatic test_reset();
        ap_rst_n = 1'b0; s_valid = 1'b0; m_ready = 1'b0; s_signed = 1'b0;
        s_a8 = '0; s_b8 = '0; s_aw = '0; s_bw = '0; s_tag = '0;
        repeat (3) @(negedge ap_clk);
        ap_rst_n = 1'b1;
        #1;
        total++; if (t_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", t_valid); end
        total++; if (t_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", t_data); end
        total++; if (t_ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", t_ovf); end
        total++; if (t_tag !== 8'h00) begin bad++; $display("FAIL reset_tag got=%h want=00", t_tag); end
        total++; if (t_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", t_ready); end
        total++; if (d_valid !== 1'b0 || d_data !== '0) begin
            bad++; $display("FAIL reset_wide got=%b/%h want=0/0", d_valid, d_data);
        end
    endtask

    task automatic test_basic();
        run_all(8'h80, 8'h80, 59'd0, 61'd0, 1'b0, 8'h5A);
        total++; if (lt != 3) begin bad++; $display("FAIL basic_latency got=%0d want=3", lt); end
        total++; if (rt_d !== 8'h40) begin bad++; $display("FAIL basic_data got=%h want=40", rt_d); end
        total++; if (rt_o !== 1'b0) begin bad++; $display("FAIL basic_ovf got=%b want=0", rt_o); end
        total++; if (rt_tag !== 8'h5A) begin bad++; $display("FAIL basic_tag got=%h want=5a", rt_tag); end
    endtask

    task automatic test_reset_midflight();
        logic seen;
        @(negedge ap_clk);
        s_a8 = 8'h40; s_b8 = 8'h40; s_aw = 59'd7; s_bw = 61'd9; s_signed = 1'b0; s_tag = 8'hC3;
        s_valid = 1'b1; m_ready = 1'b1;
        @(negedge ap_clk);
        s_valid = 1'b0; ap_rst_n = 1'b0;
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 8; n++) begin
            #1;
            if (t_valid || s4_valid || d_valid || n6_valid) seen = 1'b1;
            @(negedge ap_clk);
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL midflight_reset got=%b want=0", seen); end
    endtask

    task automatic test_rounding();
        run_all(8'h03, 8'h80, 59'd0, 61'd0, 1'b0, 8'h01);
        total++; if (rt_d !== 8'h02 || rt_o !== 1'b0) begin
            bad++; $display("FAIL rne_half_odd got=%h/%b want=02/0", rt_d, rt_o);
        end
        run_all(8'h01, 8'h80, 59'd0, 61'd0, 1'b0, 8'h02);
        total++; if (rt_d !== 8'h00 || rt_o !== 1'b0) begin
            bad++; $display("FAIL rne_half_even got=%h/%b want=00/0", rt_d, rt_o);
        end
        run_all(8'hFF, 8'h02, 59'd0, 61'd0, 1'b1, 8'h03);
        total++; if (rt_d !== 8'h00 || rt_o !== 1'b0) begin
            bad++; $display("FAIL rne_signed_neg got=%h/%b want=00/0", rt_d, rt_o);
        end
        run_all(8'h01, 8'h81, 59'd0, 61'd0, 1'b0, 8'h04);
        total++; if (rt_d !== 8'h01 || rt_o !== 1'b0) begin
            bad++; $display("FAIL rne_above_half got=%h/%b want=01/0", rt_d, rt_o);
        end
    endtask

    task automatic test_saturation();
        run_all(8'hFF, 8'hFF, 59'd0, 61'd0, 1'b0, 8'h10);
        total++; if (rs_d !== 8'hFF || rs_o !== 1'b1) begin
            bad++; $display("FAIL sat_unsigned got=%h/%b want=ff/1", rs_d, rs_o);
        end
        total++; if (rt_d !== 8'hFE || rt_o !== 1'b0) begin
            bad++; $display("FAIL nosat_shift8 got=%h/%b want=fe/0", rt_d, rt_o);
        end
        run_all(8'h80, 8'h80, 59'd0, 61'd0, 1'b1, 8'h11);
        total++; if (rs_d !== 8'h7F || rs_o !== 1'b1) begin
            bad++; $display("FAIL sat_signed_pos got=%h/%b want=7f/1", rs_d, rs_o);
        end
        run_all(8'h10, 8'h10, 59'd0, 61'd0, 1'b1, 8'h12);
        total++; if (rs_d !== 8'h10 || rs_o !== 1'b0) begin
            bad++; $display("FAIL sat_signed_inrange got=%h/%b want=10/0", rs_d, rs_o);
        end
        run_all(8'h80, 8'h7F, 59'd0, 61'd0, 1'b1, 8'h13);
        total++; if (rs_d !== 8'h80 || rs_o !== 1'b1) begin
            bad++; $display("FAIL sat_signed_neg got=%h/%b want=80/1", rs_d, rs_o);
        end
    endtask

    task automatic test_latency_wide();
        run_all(8'h00, 8'h00, 59'd3, 61'd5, 1'b0, 8'h33);
        total++; if (ld != 3) begin bad++; $display("FAIL lat_ns3 got=%0d want=3", ld); end
        total++; if (l1 != 1) begin bad++; $display("FAIL lat_ns1 got=%0d want=1", l1); end
        total++; if (l6 != 6) begin bad++; $display("FAIL lat_ns6 got=%0d want=6", l6); end
        total++; if (r6_d !== 119'd15 || r6_o !== 1'b0) begin
            bad++; $display("FAIL ns6_data got=%h/%b want=f/0", r6_d, r6_o);
        end
        total++; if (rd_tag !== 8'h33) begin bad++; $display("FAIL ns3_tag got=%h want=33", rd_tag); end
        run_all(8'h00, 8'h00, {59{1'b1}}, {61{1'b1}}, 1'b0, 8'h34);
        total++; if (rd_d !== ONES119 || rd_o !== 1'b1) begin
            bad++; $display("FAIL wide_ovf got=%h/%b want=all-ones/1", rd_d, rd_o);
        end
        total++; if (r1_d !== ONES119 || r1_o !== 1'b1) begin
            bad++; $display("FAIL wide_ovf_ns1 got=%h/%b want=all-ones/1", r1_d, r1_o);
        end
        run_all(8'h00, 8'h00, {59{1'b1}}, {61{1'b1}}, 1'b1, 8'h35);
        total++; if (rd_d !== 119'd1 || rd_o !== 1'b0) begin
            bad++; $display("FAIL wide_neg1_sq got=%h/%b want=1/0", rd_d, rd_o);
        end
        run_all(8'h00, 8'h00, {1'b1, 58'd0}, {1'b1, 60'd0}, 1'b1, 8'h36);
        total++; if (rd_d !== SMAX119 || rd_o !== 1'b1) begin
            bad++; $display("FAIL wide_min_sq got=%h/%b want=smax/1", rd_d, rd_o);
        end
    endtask

    task automatic test_back_to_back();
        int sent = 0, got = 0;
        logic hold = 1'b0;
        logic [7:0] hold_d, hold_tag;
        logic [128:0] m;
        exp_t e;
        sb.delete();
        for (int c = 0; c < 60 && got < 10; c++) begin
            @(negedge ap_clk);
            if (sent < 10) begin
                s_valid = 1'b1; s_a8 = 8'(sent * 7 + 3); s_b8 = 8'h9D; s_signed = 1'b0;
                s_tag = 8'(sent);
            end else begin
                s_valid = 1'b0;
            end
            m_ready = !(c >= 6 && c < 11);
            #1;
            if (hold) begin
                total++;
                if (t_valid !== 1'b1 || t_data !== hold_d || t_tag !== hold_tag) begin
                    bad++; $display("FAIL bp_stable got=%b/%h/%h want=1/%h/%h",
                                    t_valid, t_data, t_tag, hold_d, hold_tag);
                end
            end
            if (t_valid && !m_ready) begin
                total++;
                if (t_ready !== 1'b0) begin bad++; $display("FAIL bp_ready got=%b want=0", t_ready); end
                hold = 1'b1; hold_d = t_data; hold_tag = t_tag;
            end else begin
                hold = 1'b0;
            end
            if (s_valid && t_ready) begin
                m = model(128'(s_a8), 128'(s_b8), 1'b0, 8, 8, 8, 8);
                e.data = m[118:0]; e.ovf = m[128]; e.tag = s_tag;
                sb.push_back(e);
                sent++;
            end
            if (t_valid && m_ready) begin
                total++;
                if (sb.size() == 0) begin
                    bad++; $display("FAIL bp_extra got=tag %h want=none", t_tag);
                end else begin
                    e = sb.pop_front();
                    if (t_data !== e.data[7:0] || t_tag !== e.tag || t_ovf !== e.ovf) begin
                        bad++; $display("FAIL bp_result got=%h/%h/%b want=%h/%h/%b",
                                        t_data, t_tag, t_ovf, e.data[7:0], e.tag, e.ovf);
                    end
                end
                got++;
            end
        end
        total++; if (got != 10 || sb.size() != 0) begin
            bad++; $display("FAIL bp_count got=%0d want=10", got);
        end
    endtask

    task automatic test_random();
        int sent = 0, got = 0, cyc = 0;
        logic acc = 1'b1;
        logic [128:0] m;
        exp_t e;
        sb.delete();
        s_valid = 1'b0;
        while ((sent < 10000 || sb.size() != 0) && cyc < 60000) begin
            @(negedge ap_clk);
            cyc++;
            if (sent >= 10000) begin
                s_valid = 1'b0;
            end else if (!s_valid || acc) begin
                s_valid = ($urandom_range(0, 3) != 0);
                s_signed = $urandom_range(0, 1);
                s_tag = 8'($urandom);
                case ($urandom_range(0, 7))
                    0: s_aw = {59{1'b1}};
                    1: s_aw = {1'b1, 58'd0};
                    default: s_aw = 59'({$urandom, $urandom});
                endcase
                case ($urandom_range(0, 7))
                    0: s_bw = {61{1'b1}};
                    1: s_bw = {1'b1, 60'd0};
                    default: s_bw = 61'({$urandom, $urandom});
                endcase
            end
            m_ready = ($urandom_range(0, 3) != 0);
            #1;
            acc = s_valid && d_ready;
            if (acc) begin
                m = model(128'(s_aw), 128'(s_bw), s_signed, 59, 61, 0, 119);
                e.data = m[118:0]; e.ovf = m[128]; e.tag = s_tag;
                sb.push_back(e);
                sent++;
            end
            if (d_valid && m_ready) begin
                total++;
                if (sb.size() == 0) begin
                    bad++; $display("FAIL rand_extra got=tag %h want=none", d_tag);
                end else begin
                    e = sb.pop_front();
                    if (d_data !== e.data || d_ovf !== e.ovf || d_tag !== e.tag) begin
                        bad++; $display("FAIL rand_result #%0d got=%h/%b/%h want=%h/%b/%h",
                                        got, d_data, d_ovf, d_tag, e.data, e.ovf, e.tag);
                    end
                end
                got++;
            end
        end
        total++; if (sent != 10000 || got != 10000) begin
            bad++; $display("FAIL rand_count got=%0d/%0d want=10000/10000", sent, got);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        flush();
        test_reset_midflight();
        flush();
        test_rounding();
        test_saturation();
        test_latency_wide();
        flush();
        test_back_to_back();
        flush();
        test_random();
        flush();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pfft_mul_pipe.md
Name: pfft_mul_pipe

Overview:
- Parametrised, pipelined fixed-point multiplier for the pFFT datapath. It succeeds the single-cycle unsigned HLS multiplier cores.
- Adds a configurable pipeline depth, per-transaction signed/unsigned mode, and a right-shift with round-half-even.
- Adds saturation with an overflow flag, a tag sideband, and a valid/ready handshake with backpressure.
- Sits between posit decode (fraction alignment) and the butterfly accumulators.

Parameters:
- A_W, 59, width of operand A
- B_W, 61, width of operand B
- OUT_W, 119, width of result
- SHIFT, 0, right-shift applied to the full product before rounding; range 0..A_W+B_W-1
- NUM_STAGE, 3, pipeline latency in cycles; minimum 1
- TAG_W, 8, width of the sideband tag carried alongside each operand pair

Ports:
- ap_clk  in  1  clock; all logic on rising edge
- ap_rst_n  in  1  synchronous active-low reset
- s_valid  in  1  input operand pair valid
- s_ready  out  1  block can accept an operand pair this cycle
- s_signed  in  1  1 = both operands two's complement; 0 = both unsigned (zero-extended)
- s_a  in  A_W  operand A
- s_b  in  B_W  operand B
- s_tag  in  TAG_W  sideband, returned unchanged with the result
- m_valid  out  1  result valid
- m_ready  in  1  downstream accepts the result
- m_data  out  OUT_W  rounded, saturated result
- m_ovf  out  1  result saturated
- m_tag  out  TAG_W  tag of this result

Behaviour:
- Reset: ap_rst_n=0 at a rising edge clears every stage-valid bit. m_valid=0; m_data, m_ovf and m_tag are all 0. s_ready=1 from the first cycle after reset. Reset mid-operation discards all in-flight transactions and emits no partial results.
- Pipeline: NUM_STAGE register stages with one global advance enable. adv = !m_valid | m_ready. s_ready = adv, combinational, with no dependence on s_valid.
- Transfers: an input transfer occurs when s_valid & s_ready. An output transfer occurs when m_valid & m_ready.
- Latency: with no stall, a transfer at cycle t gives m_valid=1 at cycle t+NUM_STAGE. When adv=0 every stage holds, including bubbles, and m_* stay stable. Throughput is 1 per cycle while m_ready=1.
- Ordering: results leave in input order, and each m_tag is matched to its own result.
- Simultaneous input and output transfer in the same cycle is allowed.
- Product: the full product P is A_W+B_W bits and exact.
  - Unsigned mode: zero-extend both operands.
  - Signed mode: sign-extend both operands.
- Shift: Q = P arithmetic-shifted right by SHIFT (arithmetic in signed mode, logical in unsigned mode). R = the discarded SHIFT bits.
- Rounding (round-half-even): add 1 to Q if R > half, or if R == half and Q[0]=1; otherwise Q is unchanged. With SHIFT=0 there is no rounding.
- Saturation and overflow, evaluated after rounding:
  - Unsigned: if the value exceeds 2^OUT_W-1, m_data = all ones and m_ovf=1.
  - Signed: if the value is outside [-2^(OUT_W-1), 2^(OUT_W-1)-1], m_data clamps to the nearer bound and m_ovf=1.
  - Otherwise m_data = the low OUT_W bits of the value and m_ovf=0.
- Default-parameter exactness: with the defaults (OUT_W = A_W+B_W-1), unsigned full-range products can overflow. That is by design; the flag reports it.
- Stage mapping: implementation-defined, provided the latency is exactly NUM_STAGE. Suggested split: stage 1 registers inputs and mode; middle stages do partial products; the final stage does rounding and saturation.
- Protocol stability:
  - m_data, m_ovf and m_tag change only on an output transfer or when an empty output stage fills.
  - m_valid never drops without a transfer.
  - s_valid held high while s_ready=0 is legal and does not duplicate the transaction.

Test Plan:
(config T: A_W=8, B_W=8, OUT_W=8, SHIFT=8, NUM_STAGE=3)
- Reset, then one transfer at cycle 5: unsigned a=0x80, b=0x80 -> m_valid at cycle 8, m_data=0x40, m_ovf=0, tag returned. Assert ap_rst_n=0 on a cycle while the pipeline holds data -> nothing emitted and m_valid=0 the next cycle.
- Rounding, config T: unsigned 0x03*0x80 (exact half, odd LSB) -> 0x02. Unsigned 0x01*0x80 (exact half, even LSB) -> 0x00. Signed 0xFF*0x02 (=-2) -> 0x00.
- Saturation, config T with SHIFT=4: unsigned 0xFF*0xFF -> 0xFF, m_ovf=1. Signed 0x80*0x80 (=+16384>>4=1024) -> 0x7F, m_ovf=1. Signed 0x10*0x10 -> 0x10, m_ovf=0.
- Backpressure: stream 10 transactions with tags 0..9. Hold m_ready=0 for 5 cycles mid-stream -> s_ready=0 while m_valid=1; output holds stable; all 10 results arrive in order with no drop or duplication.
- Random traffic: 10,000 random operand/mode/tag pairs with random s_valid and m_ready at default parameters -> every result matches the golden model (exact product, RNE, saturation), in order.
- Parameter sweep: NUM_STAGE=1 and 6, SHIFT=0 -> latency is exactly NUM_STAGE. Unsigned 59-bit × 61-bit all-ones operands at default widths -> m_ovf=1, m_data all ones.
